// File: rtl/sub_halt_ctrl.sv
// Main-side sub-CPU halt/cancel controller for $FD05: halt FSM, cancel pulse, BA/BS ack sync.
// Latency: write -> SUBHALTREQn/CANCELn next cycle; raw BA/BS -> ACK 2 cycles; ACK -> SHALTSTn +1 cycle.
// Backpressure: none; writes are always accepted, a cancel write during an active pulse is dropped.
module sub_halt_ctrl #(
    parameter int CANCEL_LEN = 4,
    parameter int TMO_CYCLES = 4096
) (
    input  logic       CLK,
    input  logic       RESETBn,
    input  logic       WFD05,
    input  logic [7:0] MDATA,
    input  logic       SBA,
    input  logic       SBS,
    input  logic       BUSY,
    output logic       SUBHALTREQn,
    output logic       CANCELn,
    output logic       SHALTSTn,
    output logic [7:0] RDATA,
    output logic       HALT_TMO
);

    localparam logic [3:0]  CAN_LEN = 4'(CANCEL_LEN);
    localparam logic [15:0] TMO_LIM = 16'(TMO_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_REQ     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ba_sync_q, ba_sync_d;
    logic [1:0]  bs_sync_q, bs_sync_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_q, tmo_d;
    logic        pend_q, pend_d;
    logic [3:0]  can_cnt_q, can_cnt_d;
    logic        subhaltreq_n_q, subhaltreq_n_d;
    logic        shaltst_n_q, shaltst_n_d;
    logic        cancel_n_q, cancel_n_d;
    logic        ack;
    logic        pend_nx;

    assign ack = ba_sync_q[1] & bs_sync_q[1];

    always_comb begin
        ba_sync_d = {ba_sync_q[0], SBA};
        bs_sync_d = {bs_sync_q[0], SBS};
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        pend_d    = pend_q;
        pend_nx   = WFD05 ? MDATA[7] : pend_q;

        unique case (state_q)
            ST_RUN: begin
                if (WFD05 && MDATA[7]) begin
                    state_d   = ST_REQ;
                    tmo_cnt_d = '0;
                end
            end
            ST_REQ: begin
                if (tmo_cnt_q != TMO_LIM) tmo_cnt_d = tmo_cnt_q + 16'd1;
                // Any write this cycle outranks an ACK change.
                if (WFD05) begin
                    if (!MDATA[7]) state_d = ST_RELEASE;
                end else if (ack) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (WFD05 && !MDATA[7]) state_d = ST_RELEASE;
                else if (!ack)          state_d = ST_REQ;
            end
            ST_RELEASE: begin
                pend_d = pend_nx;
                if (!ack) begin
                    pend_d  = 1'b0;
                    state_d = pend_nx ? ST_REQ : ST_RUN;
                    if (pend_nx) tmo_cnt_d = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase

        tmo_d          = tmo_q | ((state_q == ST_REQ) && (tmo_cnt_d == TMO_LIM));
        subhaltreq_n_d = !((state_d == ST_REQ) || (state_d == ST_HALTED));
        shaltst_n_d    = (state_d != ST_HALTED);

        if (can_cnt_q != 4'd0)          can_cnt_d = can_cnt_q - 4'd1;
        else if (WFD05 && MDATA[6])     can_cnt_d = CAN_LEN;
        else                            can_cnt_d = 4'd0;
        cancel_n_d = (can_cnt_d == 4'd0);
    end

    always_ff @(posedge CLK or negedge RESETBn) begin
        if (!RESETBn) begin
            state_q        <= ST_RUN;
            ba_sync_q      <= 2'b00;
            bs_sync_q      <= 2'b00;
            tmo_cnt_q      <= '0;
            tmo_q          <= 1'b0;
            pend_q         <= 1'b0;
            can_cnt_q      <= 4'd0;
            subhaltreq_n_q <= 1'b1;
            shaltst_n_q    <= 1'b1;
            cancel_n_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            ba_sync_q      <= ba_sync_d;
            bs_sync_q      <= bs_sync_d;
            tmo_cnt_q      <= tmo_cnt_d;
            tmo_q          <= tmo_d;
            pend_q         <= pend_d;
            can_cnt_q      <= can_cnt_d;
            subhaltreq_n_q <= subhaltreq_n_d;
            shaltst_n_q    <= shaltst_n_d;
            cancel_n_q     <= cancel_n_d;
        end
    end

    assign SUBHALTREQn = subhaltreq_n_q;
    assign SHALTSTn    = shaltst_n_q;
    assign CANCELn     = cancel_n_q;
    assign HALT_TMO    = tmo_q;
    assign RDATA       = {BUSY, 6'b111111, tmo_q};

endmodule

// File: doc/sub_halt_ctrl.md
Name: sub_halt_ctrl

Overview:
- Main-side controller for the sub-CPU halt/cancel handshake at main I/O address $FD05. It sits directly upstream of the sub-system flag block and drives its SUBHALTREQn, CANCELn and SHALTSTn inputs.
- Main-CPU writes to $FD05 request a sub-CPU halt (bit7) or raise a cancel/IRQ (bit6).
- The block synchronises the sub-CPU BA/BS halt acknowledge and runs the halt state machine.
- It returns the busy status for main reads of $FD05.

Parameters:
- CANCEL_LEN, 4, cycles CANCELn is held low per cancel request (1..15).
- TMO_CYCLES, 4096, cycles allowed in REQ before the timeout flag sets (1..65535).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESETBn  in  1  asynchronous active-low reset.
- WFD05  in  1  one-cycle write strobe for main $FD05, qualified in CLK domain.
- MDATA  in  8  main data bus, sampled when WFD05=1.
- SBA  in  1  sub-CPU BA, asynchronous.
- SBS  in  1  sub-CPU BS, asynchronous.
- BUSY  in  1  sub busy flag from the flag block.
- SUBHALTREQn  out  1  halt request to the sub CPU and flag block; low = request.
- CANCELn  out  1  cancel pulse; the flag block acts on its rising edge.
- SHALTSTn  out  1  low = sub CPU confirmed halted; gates the shared-RAM window.
- RDATA  out  8  $FD05 read value.
- HALT_TMO  out  1  sticky halt-acknowledge timeout flag.

Behaviour:
- Reset (async, RESETBn=0):
  - SUBHALTREQn=1, CANCELn=1, SHALTSTn=1, HALT_TMO=0.
  - State RUN; all counters 0; synchronisers cleared to 0; pending flag 0.
- Acknowledge:
  - ACK = SBA & SBS, taken after a 2-flop synchroniser.
  - Raw SBA/SBS edges reach ACK 2 cycles later.
- RDATA (combinational):
  - {BUSY, 6'b111111, HALT_TMO}.
  - Reads never change state.
- Write decode on a WFD05 cycle:
  - MDATA[7] sets the halt-request target H.
  - MDATA[6]=1 starts a cancel pulse.
  - Other bits are ignored.
- Cancel pulse:
  - The cycle after a bit6 write, CANCELn goes 0 for exactly CANCEL_LEN cycles, then returns to 1.
  - A bit6 write while the pulse is active is ignored: no retrigger, no extension.
  - The pulse runs independently of the halt FSM.
- Halt FSM (registered; outputs change the cycle after the transition event):
  - RUN: SUBHALTREQn=1, SHALTSTn=1. Write with H=1 -> REQ; timeout counter cleared.
  - REQ: SUBHALTREQn=0, SHALTSTn=1; timeout counter increments each cycle.
    - ACK=1 -> HALTED.
    - Write with H=0 -> RELEASE.
    - Counter reaches TMO_CYCLES -> HALT_TMO sets and stays set until reset. The state remains REQ.
  - HALTED: SUBHALTREQn=0, SHALTSTn=0.
    - Write with H=0 -> RELEASE.
    - If ACK drops while still requested, SHALTSTn returns to 1 and the state returns to REQ. The counter is not cleared and HALT_TMO is unaffected.
  - RELEASE: SUBHALTREQn=1, SHALTSTn=1.
    - ACK=0 -> RUN, or -> REQ if the pending flag is set; pending then clears.
    - Write with H=1 sets the pending flag.
- HALT_TMO is cleared only by reset.
- Simultaneous events:
  - A write and an ACK change in the same cycle in REQ: the write takes priority.
  - A bit6+bit7 write applies both actions in the same cycle.
- SHALTSTn never goes 0 while SUBHALTREQn=1.
- Reset mid-pulse or mid-handshake forces every output to its reset value immediately, without waiting for CLK.

Test Plan:
- Reset release, no stimulus -> SUBHALTREQn=1, CANCELn=1, SHALTSTn=1, RDATA=8'h7E with BUSY=0 and 8'hFE with BUSY=1.
- Write 8'h80, then assert SBA=SBS=1 at cycle 5 -> SUBHALTREQn=0 from cycle 1; SHALTSTn=0 at cycle 8 (2 sync + 1 FSM).
- From HALTED, write 8'h00 -> SUBHALTREQn=1 and SHALTSTn=1 next cycle. Drop SBA/SBS, then write 8'h80 during RELEASE -> returns to REQ only after ACK is seen 0.
- Write 8'h40 -> CANCELn low for exactly 4 cycles. A second 8'h40 at pulse cycle 2 -> still 4 cycles total.
- Write 8'h80 with SBA held 0, TMO_CYCLES=16 -> HALT_TMO=1 after 16 cycles and RDATA[0]=1. A later write of 8'h00 leaves HALT_TMO=1.
- Assert RESETBn=0 mid-pulse while HALTED -> all outputs at reset values with no clock edge required.
